// File: rtl/muldiv_controller_if.sv
// Bus bundle between the EX-stage pipeline and the multiply/divide controller.
// The pipeline drives the "master" side; the controller is the "slave" side.
interface muldiv_controller_if;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] rs_data_i;
   logic [31:0] rt_data_i;
   logic        flush_i;
   logic        ID_mfhilo_i;
   logic        ID_muldiv_i;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        busy_o;
   logic        stall_o;
   logic        done_o;

   modport master (
      output start_i, op_i, rs_data_i, rt_data_i, flush_i, ID_mfhilo_i, ID_muldiv_i,
      input  hi_o, lo_o, busy_o, stall_o, done_o
   );

   modport slave (
      input  start_i, op_i, rs_data_i, rt_data_i, flush_i, ID_mfhilo_i, ID_muldiv_i,
      output hi_o, lo_o, busy_o, stall_o, done_o
   );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative 32-cycle MIPS multiply/divide unit with HI/LO registers and pipeline stall.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU are no-ops.
module muldiv_controller (
   input  logic               clk,
   input  logic               reset,
   muldiv_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [4:0]  count_reg;

   logic        busy;
   logic        accept;
   logic        stall;
   logic        op_ok;
   logic        signed_op;
   logic [31:0] rs_mag;
   logic [31:0] rt_mag;

   logic [63:0] acc_reg;
   logic [63:0] acc_step;
   logic [63:0] product;
   logic [32:0] mul_sum;
   logic [31:0] a_reg;
   logic        neg_q_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic        done_reg;

`ifdef MULDIV_DIV_EN
   logic        div_reg;
   logic        neg_r_reg;
   logic        div_zero_reg;
   logic [31:0] b_reg;
   logic [31:0] rs_orig_reg;
   logic [32:0] div_diff;
   logic [31:0] quot;
   logic [31:0] rem;

   assign op_ok = 1'b1;
`else
   // Divide ops are swallowed in IDLE: never start the engine for them.
   assign op_ok = ~bus.op_i[1];
`endif

   assign signed_op = ~bus.op_i[0];
   assign rs_mag    = (signed_op && bus.rs_data_i[31]) ? (32'd0 - bus.rs_data_i) : bus.rs_data_i;
   assign rt_mag    = (signed_op && bus.rt_data_i[31]) ? (32'd0 - bus.rt_data_i) : bus.rt_data_i;

   // State register and iteration counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         count_reg <= 5'd0;
      end else begin
         state_reg <= state_next;
         count_reg <= (state_reg == RUN) ? (count_reg + 5'd1) : 5'd0;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (count_reg == 5'd31) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy   = (state_reg != IDLE);
      accept = (state_reg == IDLE) && bus.start_i && !bus.flush_i && !reset && op_ok;
      stall  = (busy || accept) && (bus.ID_mfhilo_i || bus.ID_muldiv_i);
   end

   // One radix-2 step of the selected algorithm on the accumulator
   always_comb begin
      mul_sum  = {1'b0, acc_reg[63:32]} + {1'b0, a_reg};
      acc_step = acc_reg[0] ? {mul_sum, acc_reg[31:1]} : {1'b0, acc_reg[63:1]};
`ifdef MULDIV_DIV_EN
      // Partial remainder is 33 bits wide so the shifted-in MSB is never lost.
      div_diff = acc_reg[63:31] - {1'b0, b_reg};
      if (div_reg) begin
         acc_step = div_diff[32] ? {acc_reg[62:0], 1'b0}
                                 : {div_diff[31:0], acc_reg[30:0], 1'b1};
      end
`endif
   end

   // Sign correction applied on the way out of FIX
   always_comb begin
      product = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
`ifdef MULDIV_DIV_EN
      quot = neg_q_reg ? (32'd0 - acc_reg[31:0])  : acc_reg[31:0];
      rem  = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg   <= 64'd0;
         a_reg     <= 32'd0;
         neg_q_reg <= 1'b0;
         hi_reg    <= 32'd0;
         lo_reg    <= 32'd0;
         done_reg  <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_reg      <= 1'b0;
         neg_r_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         b_reg        <= 32'd0;
         rs_orig_reg  <= 32'd0;
`endif
      end else begin
         done_reg <= 1'b0;
         if (accept) begin
            a_reg     <= rs_mag;
            neg_q_reg <= signed_op && (bus.rs_data_i[31] ^ bus.rt_data_i[31]);
            acc_reg   <= {32'd0, rt_mag};
`ifdef MULDIV_DIV_EN
            div_reg      <= bus.op_i[1];
            neg_r_reg    <= signed_op && bus.rs_data_i[31];
            div_zero_reg <= (bus.rt_data_i == 32'd0);
            b_reg        <= rt_mag;
            rs_orig_reg  <= bus.rs_data_i;
            if (bus.op_i[1]) acc_reg <= {32'd0, rs_mag};
`endif
         end
         if (state_reg == RUN) acc_reg <= acc_step;
         if (state_reg == FIX) begin
            done_reg <= 1'b1;
            hi_reg   <= product[63:32];
            lo_reg   <= product[31:0];
`ifdef MULDIV_DIV_EN
            if (div_reg) begin
               hi_reg <= div_zero_reg ? rs_orig_reg : rem;
               lo_reg <= div_zero_reg ? 32'hFFFF_FFFF : quot;
            end
`endif
         end
      end
   end

   assign bus.hi_o    = hi_reg;
   assign bus.lo_o    = lo_reg;
   assign bus.busy_o  = busy;
   assign bus.stall_o = stall;
   assign bus.done_o  = done_reg;

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: directed vector table, hand-written
// flush/reset sequences and random ops checked against an arithmetic reference model.
module tb_muldiv_controller;

   logic clk;
   logic reset;
   muldiv_controller_if bus ();

   muldiv_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef MULDIV_DIV_EN
   localparam logic DIV_BUILD = 1'b1;
`else
   localparam logic DIV_BUILD = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] prev_hi;
   logic [31:0] prev_lo;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        mfh;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference results from plain 64-bit arithmetic
   task automatic model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output logic [31:0] hi, output logic [31:0] lo);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub;
      logic [63:0]     t;
      sa = longint'($signed(rs));
      sb = longint'($signed(rt));
      ua = {32'd0, rs};
      ub = {32'd0, rt};
      t  = 64'd0;
      case (op)
         2'b00: t = sa * sb;
         2'b01: t = ua * ub;
         2'b10: begin
            if (rt == 32'd0) t = {rs, 32'hFFFF_FFFF};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               t  = {sr[31:0], sq[31:0]};
            end
         end
         default: begin
            if (rt == 32'd0) t = {rs, 32'hFFFF_FFFF};
            else t = {rs % rt, rs / rt};
         end
      endcase
      hi = t[63:32];
      lo = t[31:0];
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic mfh, input logic mdv, input logic valid,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
      int   bad;
      logic haz;
      bad = 0;
      haz = mfh | mdv;
      @(negedge clk);
      bus.start_i     = 1'b1;
      bus.op_i        = op;
      bus.rs_data_i   = rs;
      bus.rt_data_i   = rt;
      bus.flush_i     = 1'b0;
      bus.ID_mfhilo_i = mfh;
      bus.ID_muldiv_i = mdv;
      #1 check({name, "_stall_n"}, 64'(bus.stall_o), 64'(valid & haz));
      @(negedge clk);
      bus.start_i = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         #1;
         if (bus.busy_o !== valid) bad++;
         if (bus.done_o !== 1'b0) bad++;
         if (bus.stall_o !== (valid & haz)) bad++;
         if (valid && k == 5) begin
            bus.start_i   = 1'b1;
            bus.op_i      = 2'($urandom_range(0, 3));
            bus.rs_data_i = $urandom;
            bus.rt_data_i = $urandom;
         end
         if (k == 6) bus.start_i = 1'b0;
         if (valid && k == 8) bus.flush_i = 1'b1;
         if (k == 9) bus.flush_i = 1'b0;
         @(negedge clk);
      end
      #1;
      check({name, "_done"},  64'(bus.done_o),  64'(valid));
      check({name, "_busy"},  64'(bus.busy_o),  64'd0);
      check({name, "_stall"}, 64'(bus.stall_o), 64'd0);
      check({name, "_hi"},    64'(bus.hi_o),    64'(exp_hi));
      check({name, "_lo"},    64'(bus.lo_o),    64'(exp_lo));
      @(negedge clk);
      #1 check({name, "_done_drop"}, 64'(bus.done_o), 64'd0);
      check({name, "_run"}, 64'(bad), 64'd0);
      bus.ID_mfhilo_i = 1'b0;
      bus.ID_muldiv_i = 1'b0;
      $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h (%s)", op, rs, rt, bus.hi_o, bus.lo_o, name);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        valid;
      logic [31:0] eh;
      logic [31:0] el;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [1:0]  op;
      int          cnt;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{2'b11, 32'd10,        32'd0,         1'b1, 32'h0000_000A, 32'hFFFF_FFFF};
      vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
      vecs[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[7] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vecs[8] = '{2'b11, 32'hFFFF_FFFF, 32'd16,        1'b0, 32'h0000_000F, 32'h0FFF_FFFF};
      vecs[9] = '{2'b00, 32'd7,         32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

      reset           = 1'b1;
      bus.start_i     = 1'b0;
      bus.op_i        = 2'b00;
      bus.rs_data_i   = 32'd0;
      bus.rt_data_i   = 32'd0;
      bus.flush_i     = 1'b0;
      bus.ID_mfhilo_i = 1'b1;
      bus.ID_muldiv_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_hi",    64'(bus.hi_o),    64'd0);
      check("rst_lo",    64'(bus.lo_o),    64'd0);
      check("rst_busy",  64'(bus.busy_o),  64'd0);
      check("rst_done",  64'(bus.done_o),  64'd0);
      check("rst_stall", 64'(bus.stall_o), 64'd0);
      reset = 1'b0;
      bus.ID_mfhilo_i = 1'b0;
      prev_hi = 32'd0;
      prev_lo = 32'd0;

      for (int i = 0; i < 10; i++) begin
         valid = DIV_BUILD | ~vecs[i].op[1];
         eh = valid ? vecs[i].hi : prev_hi;
         el = valid ? vecs[i].lo : prev_lo;
         do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].mfh, 1'b0, valid, eh, el,
               $sformatf("vec%0d", i));
         prev_hi = eh;
         prev_lo = el;
      end

      // Flushed start must be ignored
      @(negedge clk);
      bus.start_i     = 1'b1;
      bus.flush_i     = 1'b1;
      bus.op_i        = 2'b00;
      bus.rs_data_i   = 32'd1234;
      bus.rt_data_i   = 32'd99;
      bus.ID_mfhilo_i = 1'b1;
      #1 check("flush_stall", 64'(bus.stall_o), 64'd0);
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.ID_mfhilo_i = 1'b0;
      #1 check("flush_busy", 64'(bus.busy_o), 64'd0);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1 if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) cnt++;
      end
      check("flush_quiet", 64'(cnt), 64'd0);
      check("flush_hi", 64'(bus.hi_o), 64'(prev_hi));
      check("flush_lo", 64'(bus.lo_o), 64'(prev_lo));
      $display("flushed start: busy=%0d hi=%h lo=%h", bus.busy_o, bus.hi_o, bus.lo_o);

      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         rs = $urandom;
         case ($urandom_range(0, 7))
            0:       rt = 32'd0;
            1:       rt = $urandom_range(1, 9);
            2:       rt = 32'hFFFF_FFFF;
            default: rt = $urandom;
         endcase
         if (($urandom_range(0, 3)) == 0) rs = $urandom_range(0, 20);
         valid = DIV_BUILD | ~op[1];
         model(op, rs, rt, eh, el);
         eh = valid ? eh : prev_hi;
         el = valid ? el : prev_lo;
         do_op(op, rs, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), valid, eh, el,
               $sformatf("rnd%0d", i));
         prev_hi = eh;
         prev_lo = el;
      end

      // Reset in the 10th RUN cycle discards the operation
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = 2'b01;
      bus.rs_data_i = 32'd123;
      bus.rt_data_i = 32'd456;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rrun_busy", 64'(bus.busy_o), 64'd0);
      check("rrun_hi",   64'(bus.hi_o),   64'd0);
      check("rrun_lo",   64'(bus.lo_o),   64'd0);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1 if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) cnt++;
      end
      check("rrun_no_done", 64'(cnt), 64'd0);
      $display("reset mid-run: busy=%0d hi=%h lo=%h", bus.busy_o, bus.hi_o, bus.lo_o);

      do_op(2'b01, 32'd123, 32'd456, 1'b0, 1'b1, 1'b1, 32'd0, 32'd56088, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
